// File: rtl/wf_player.sv
// wf_player: plays 16-bit samples from the waveform DPBRAM at a programmable
// period, one-shot or looping, with valid/done strobes and a sample count.
module wf_player #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  i_wf_mode_start,
    input  logic                  i_wf_write_en,
    input  logic [CNT_WIDTH-1:0]  i_wf_length,
    input  logic [CNT_WIDTH-1:0]  i_wf_period,
    input  logic                  i_wf_loop,
    output logic                  o_bram_en,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    input  logic [DATA_WIDTH-1:0] i_bram_data,
    output logic [DATA_WIDTH-1:0] o_wf_data,
    output logic                  o_wf_valid,
    output logic                  o_wf_busy,
    output logic                  o_wf_done,
    output logic                  o_wf_err,
    output logic [CNT_WIDTH-1:0]  o_wf_sample_cnt
);
    localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(1) << ADDR_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q;
    logic                  start_q, en_q, pend_q, valid_q, done_q, busy_q, err_q, loop_q;
    logic [ADDR_WIDTH-1:0] addr_q, last_q, addr_d;
    logic [CNT_WIDTH-1:0]  per_q, prd_q, len_q, fcnt_q, cnt_q, prd_d, cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  start_edge, len_ok, abort, tick, more;

    assign start_edge = i_wf_mode_start & ~start_q;
    assign len_ok     = (i_wf_length != '0) && (i_wf_length <= DEPTH);
    assign abort      = ~i_wf_mode_start | i_wf_write_en;
    assign tick       = per_q == '0;
    assign more       = loop_q | (fcnt_q != len_q);
    assign prd_d      = i_wf_period < CNT_WIDTH'(2) ? CNT_WIDTH'(2) : i_wf_period;
    assign addr_d     = addr_q == last_q ? '0 : addr_q + 1'b1;
    assign cnt_d      = cnt_q + 1'b1;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            loop_q  <= 1'b0;
            addr_q  <= '0;
            last_q  <= '0;
            per_q   <= '0;
            prd_q   <= '0;
            len_q   <= '0;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            start_q <= i_wf_mode_start;
            en_q    <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (start_edge && (i_wf_write_en || !len_ok)) begin
                    err_q <= 1'b1;
                end else if (start_edge) begin
                    err_q   <= 1'b0;
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                    en_q    <= 1'b1;
                    addr_q  <= '0;
                    fcnt_q  <= CNT_WIDTH'(1);
                    cnt_q   <= '0;
                    len_q   <= i_wf_length;
                    last_q  <= ADDR_WIDTH'(i_wf_length - 1'b1);
                    prd_q   <= prd_d;
                    per_q   <= prd_d - 1'b1;
                    loop_q  <= i_wf_loop;
                end
            end else if (done_q || abort) begin
                // an in-flight fetch is dropped simply by not forwarding pend_q
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                pend_q <= en_q;
                if (pend_q) begin
                    data_q  <= i_bram_data;
                    valid_q <= 1'b1;
                    cnt_q   <= cnt_d;
                    done_q  <= ~loop_q && (cnt_d == len_q);
                end
                per_q <= tick ? prd_q - 1'b1 : per_q - 1'b1;
                if (tick && more) begin
                    en_q   <= 1'b1;
                    addr_q <= addr_d;
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end
        end
    end

    assign o_bram_en       = en_q;
    assign o_bram_addr     = addr_q;
    assign o_wf_data       = data_q;
    assign o_wf_valid      = valid_q;
    assign o_wf_busy       = busy_q;
    assign o_wf_done       = done_q;
    assign o_wf_err        = err_q;
    assign o_wf_sample_cnt = cnt_q;
endmodule

// File: tb/tb_wf_player.sv
// tb_wf_player: scoreboard bench for wf_player; expected fetches and samples
// are queued by the stimulus and popped by a negedge monitor.
module tb_wf_player;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [31:0] i_wf_length = '0;
    logic [31:0] i_wf_period = '0;
    logic        i_wf_loop = 1'b0;
    logic        o_bram_en;
    logic [9:0]  o_bram_addr;
    logic [15:0] bram_data = '0;
    logic [15:0] o_wf_data;
    logic        o_wf_valid, o_wf_busy, o_wf_done, o_wf_err;
    logic [31:0] o_wf_sample_cnt;

    typedef struct {int c; int v; int n; bit d;} ev_t;
    ev_t fq[$];
    ev_t vq[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    wf_player dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_wf_mode_start(start),
        .i_wf_write_en(we), .i_wf_length(i_wf_length), .i_wf_period(i_wf_period),
        .i_wf_loop(i_wf_loop), .o_bram_en(o_bram_en), .o_bram_addr(o_bram_addr),
        .i_bram_data(bram_data), .o_wf_data(o_wf_data), .o_wf_valid(o_wf_valid),
        .o_wf_busy(o_wf_busy), .o_wf_done(o_wf_done), .o_wf_err(o_wf_err),
        .o_wf_sample_cnt(o_wf_sample_cnt)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // BRAM model preloaded with addr*3
    always @(posedge clk) if (o_bram_en) bram_data <= {6'b0, o_bram_addr} * 16'd3;

    task automatic chk(input string nm, input longint a, input longint e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic extra(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected strobe at cycle %0d", nm, cyc);
    endtask

    task automatic tick1;
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int L, input int P, input bit lp, input int stop, input bit rs);
        int n, pe, nv, m;
        tick1();
        i_wf_length = L;
        i_wf_period = P;
        i_wf_loop = lp;
        start = 1'b1;
        n = cyc;
        pe = P < 2 ? 2 : P;
        nv = 0;
        m = stop >= 0 ? n + stop : n + 3 + (L - 1) * pe;
        for (int k = 0; lp || k < L; k++) begin
            if (n + 1 + k * pe > m) break;
            fq.push_back('{n + 1 + k * pe, k % L, 0, 1'b0});
            if (n + 3 + k * pe <= m) begin
                vq.push_back('{n + 3 + k * pe, (k % L) * 3, k + 1, !lp && k == L - 1});
                nv = k + 1;
            end
        end
        tick1();
        chk("busy_start", o_wf_busy, 1);
        chk("cnt_start", o_wf_sample_cnt, 0);
        chk("err_start", o_wf_err, 0);
        i_wf_length = 7;
        i_wf_period = 3;
        i_wf_loop = !lp;
        while (cyc < m) tick1();
        if (stop >= 0) begin
            if (rs) rst_n = 1'b0;
            start = 1'b0;
        end else chk("busy_last", o_wf_busy, 1);
        tick1();
        chk("busy_end", o_wf_busy, 0);
        chk("cnt_end", o_wf_sample_cnt, rs ? 0 : nv);
        chk("data_end", o_wf_data, rs ? 0 : ((nv - 1) % L) * 3);
        if (rs) begin
            chk("rst_valid", o_wf_valid, 0);
            chk("rst_done", o_wf_done, 0);
            chk("rst_en", o_bram_en, 0);
            chk("rst_addr", o_bram_addr, 0);
            chk("rst_err", o_wf_err, 0);
        end
        rst_n = 1'b1;
        if (stop < 0) begin
            repeat (6) tick1();
            chk("hold_busy", o_wf_busy, 0);
            start = 1'b0;
        end
        repeat (3) tick1();
    endtask

    task automatic rej(input int L, input bit w);
        tick1();
        i_wf_length = L;
        we = w;
        start = 1'b1;
        tick1();
        chk("rej_err", o_wf_err, 1);
        chk("rej_busy", o_wf_busy, 0);
        start = 1'b0;
        we = 1'b0;
        repeat (2) tick1();
    endtask

    initial begin
        fork
            begin
                repeat (3) tick1();
                chk("rst_busy0", o_wf_busy, 0);
                chk("rst_data0", o_wf_data, 0);
                chk("rst_cnt0", o_wf_sample_cnt, 0);
                chk("rst_err0", o_wf_err, 0);
                rst_n = 1'b1;
                repeat (2) tick1();
                play(8, 4, 1'b1, 20, 1'b1);
                play(4, 5, 1'b0, -1, 1'b0);
                play(3, 0, 1'b1, 21, 1'b0);
                rej(0, 1'b0);
                rej(1025, 1'b0);
                rej(4, 1'b1);
                play(16, 10, 1'b0, 43, 1'b0);
                play(1, 3, 1'b0, -1, 1'b0);
                play(1024, 2, 1'b1, 3 + 1029 * 2, 1'b0);
                repeat (5) tick1();
            end
            forever begin
                ev_t e;
                @(negedge clk);
                if (fq.size() > 0 && fq[0].c < cyc) begin
                    e = fq.pop_front();
                    chk("fetch_missed", cyc, e.c);
                end
                if (vq.size() > 0 && vq[0].c < cyc) begin
                    e = vq.pop_front();
                    chk("valid_missed", cyc, e.c);
                end
                if (o_bram_en) begin
                    if (fq.size() == 0) extra("fetch_extra");
                    else begin
                        e = fq.pop_front();
                        chk("fetch_cyc", cyc, e.c);
                        chk("fetch_addr", o_bram_addr, e.v);
                    end
                end
                if (o_wf_valid) begin
                    if (vq.size() == 0) extra("valid_extra");
                    else begin
                        e = vq.pop_front();
                        chk("valid_cyc", cyc, e.c);
                        chk("valid_data", o_wf_data, e.v);
                        chk("valid_cnt", o_wf_sample_cnt, e.n);
                        chk("valid_done", o_wf_done, e.d);
                    end
                end else if (o_wf_done) extra("done_extra");
            end
        join_any
        disable fork;
        chk("fq_empty", fq.size(), 0);
        chk("vq_empty", vq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
